// File: rtl/output_fifo_pkg.sv
// ---------------------------------------------------------------------------
// output_fifo_pkg
// Shared definitions for the convolution output FIFO and its controller:
//   - fifo_command encodings (CMD_IDLE / CMD_WRITE / CMD_READ / CMD_ILLEGAL)
//   - FSM state encoding (state_t)
//   - default data width and depth
// ---------------------------------------------------------------------------
package output_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 20;
    localparam int DEFAULT_DEPTH      = 256;

    localparam logic [1:0] CMD_IDLE    = 2'b00;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

endpackage

// File: rtl/output_fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage, DEPTH x DATA_WIDTH. Synchronous write, registered
// read (data appears the cycle after rd_en). The array itself is not reset;
// only the read register is, so rd_data comes out of reset as zero.
// Ports:
//   clk, reset (async, active-low)
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr, rd_data : read port, rd_data holds when rd_en is low
// ---------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/output_fifo.sv
// ---------------------------------------------------------------------------
// output_fifo
// Buffers convolution results. The controller issues level commands; a write
// happens once per rising edge of the write command. Reads are popped by the
// external MEM_READ request while the block is draining.
// Ports:
//   clk, reset (async, active-low)
//   fifo_command[1:0] : 00 idle, 10 write, 01 read/drain, 11 illegal
//   wr_data           : word written on a write event
//   MEM_READ          : pop request (honoured only in DRAIN)
//   rd_data, rd_valid : popped word, valid one cycle after the pop
//   full, empty, count: occupancy
//   drain_done        : one-cycle pulse after DRAIN returns to IDLE
//   overflow, underflow, cmd_error : sticky error flags
// ---------------------------------------------------------------------------
module output_fifo
    import output_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            fifo_command,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  MEM_READ,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  drain_done,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  cmd_error
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    state_t                  state_reg;
    logic [1:0]              cmd_q_reg;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
    logic [ADDR_WIDTH-1:0]   rd_ptr_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic [ADDR_WIDTH:0]     count_next;
    logic                    rd_valid_reg;
    logic                    drain_done_reg;
    logic                    overflow_reg;
    logic                    underflow_reg;
    logic                    cmd_error_reg;

    logic                    full_w;
    logic                    empty_w;
    logic                    write_event;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    rd_refused;

    // Occupancy comes from the counter only; pointers alone are ambiguous
    // when they are equal.
    assign full_w  = (count_reg == DEPTH_CNT);
    assign empty_w = (count_reg == '0);

    // The write command is a level; only its rising edge writes a word.
    assign write_event = (fifo_command == CMD_WRITE) && (cmd_q_reg != CMD_WRITE);
    assign wr_accept   = write_event && !full_w;
    assign rd_accept   = (state_reg == ST_DRAIN) && MEM_READ && !empty_w;
    assign rd_refused  = (state_reg == ST_DRAIN) && MEM_READ && empty_w;

    always_comb begin
        count_next = count_reg;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Control FSM. Leaving DRAIN waits until the last popped word has been
    // presented (rd_valid low) so drain_done never precedes the final data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            drain_done_reg <= 1'b0;
        end else begin
            drain_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (write_event) begin
                        state_reg <= ST_FILL;
                    end else if (fifo_command == CMD_READ) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_FILL: begin
                    if (fifo_command == CMD_READ) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (write_event) begin
                        state_reg <= ST_FILL;
                    end else if (empty_w && !rd_valid_reg) begin
                        state_reg      <= ST_IDLE;
                        drain_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Pointers, occupancy and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q_reg     <= CMD_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            cmd_error_reg <= 1'b0;
        end else begin
            cmd_q_reg    <= fifo_command;
            count_reg    <= count_next;
            rd_valid_reg <= rd_accept;
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (write_event && full_w) begin
                overflow_reg <= 1'b1;
            end
            if (rd_refused) begin
                underflow_reg <= 1'b1;
            end
            if (fifo_command == CMD_ILLEGAL) begin
                cmd_error_reg <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    assign rd_valid   = rd_valid_reg;
    assign full       = full_w;
    assign empty      = empty_w;
    assign count      = count_reg;
    assign drain_done = drain_done_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;
    assign cmd_error  = cmd_error_reg;

endmodule
